nibble_array_reader: RTL and testbench

- Consumer end of the constant nibble-array output interface: takes a flattened 4x2x3 array of 4-bit elements and snapshots it on request.
- Streams the elements one per handshake over a valid/ready channel, then reports an XOR/additive checksum.
- Sits between array-producing modules and the stream checkers/loggers in the test harness.

---
 rtl/nibble_array_pkg.sv | 22 ++
 rtl/nibble_checksum_acc.sv | 34 +++
 rtl/nibble_array_reader.sv | 90 +++++++++
 tb/tb_nibble_array_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_array_pkg.sv
// rtl/nibble_array_pkg.sv - shared geometry, reader states and element ordering for the nibble array
package nibble_array_pkg;

    localparam int D0 = 4;
    localparam int D1 = 2;
    localparam int D2 = 3;
    localparam int W  = 4;
    localparam int N  = D0 * D1 * D2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        SUM    = 2'd3
    } rd_state_e;

    // Innermost index is stored descending so [a][b][D2-1] lands at the lowest k of its row.
    function automatic int flat_index(input int a, input int b, input int c);
        return (a * D1 + b) * D2 + (D2 - 1 - c);
    endfunction

endpackage

// File: rtl/nibble_checksum_acc.sv
// rtl/nibble_checksum_acc.sv - running XOR and zero-extended additive checksum of streamed elements
module nibble_checksum_acc #(
    parameter int W  = nibble_array_pkg::W,
    parameter int CW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            acc_en_i,
    input  logic [W-1:0]    elem_i,
    output logic [W-1:0]    sum_xor_o,
    output logic [W+CW-1:0] sum_add_o
);

    logic [W-1:0]    xor_q;
    logic [W+CW-1:0] add_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_q <= '0;
            add_q <= '0;
        end else if (clear_i) begin
            xor_q <= '0;
            add_q <= '0;
        end else if (acc_en_i) begin
            xor_q <= xor_q ^ elem_i;
            add_q <= add_q + {{CW{1'b0}}, elem_i};
        end
    end

    assign sum_xor_o = xor_q;
    assign sum_add_o = add_q;

endmodule

// File: rtl/nibble_array_reader.sv
// rtl/nibble_array_reader.sv - snapshots a flattened nibble array and streams it out with a closing checksum
module nibble_array_reader #(
    parameter int D0 = nibble_array_pkg::D0,
    parameter int D1 = nibble_array_pkg::D1,
    parameter int D2 = nibble_array_pkg::D2,
    parameter int W  = nibble_array_pkg::W,
    localparam int N  = D0 * D1 * D2,
    localparam int CW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N*W-1:0]  arr_flat,
    output logic            busy,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [W-1:0]    o_data,
    output logic [CW-1:0]   o_index,
    output logic            o_last,
    output logic            sum_valid,
    output logic [W-1:0]    sum_xor,
    output logic [W+CW-1:0] sum_add
);
    import nibble_array_pkg::*;

    rd_state_e      state_q, state_d;
    logic [N*W-1:0] snap_q;
    logic [CW-1:0]  k_q, k_d;
    logic           accept;
    logic           fire;

    assign accept = (state_q == IDLE) && start;
    assign fire   = (state_q == STREAM) && o_ready;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    k_d     = '0;
                end
            end
            LOAD:   state_d = STREAM;
            STREAM: begin
                if (fire) begin
                    // k parks on the last index rather than wrapping past N-1
                    if (k_q == CW'(N - 1)) state_d = SUM;
                    else                   k_d     = k_q + CW'(1);
                end
            end
            SUM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) snap_q <= arr_flat;
        end
    end

    nibble_checksum_acc #(
        .W  (W),
        .CW (CW)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (accept),
        .acc_en_i  (fire),
        .elem_i    (o_data),
        .sum_xor_o (sum_xor),
        .sum_add_o (sum_add)
    );

    assign o_data    = snap_q[k_q*W +: W];
    assign o_index   = k_q;
    assign o_valid   = (state_q == STREAM);
    assign o_last    = o_valid && (k_q == CW'(N - 1));
    assign busy      = (state_q != IDLE);
    assign sum_valid = (state_q == SUM);

endmodule

// File: tb/tb_nibble_array_reader.sv
// tb/tb_nibble_array_reader.sv - randomized scoreboard bench for nibble_array_reader
module tb_nibble_array_reader;
    import nibble_array_pkg::*;

    localparam int CW = $clog2(N + 1);

    typedef struct {
        logic [W-1:0]  data;
        logic [CW-1:0] idx;
        logic          last;
    } beat_t;

    typedef struct {
        logic [W-1:0]    x;
        logic [W+CW-1:0] s;
    } sum_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N*W-1:0]  arr_flat;
    logic            busy;
    logic            o_valid;
    logic            o_ready;
    logic [W-1:0]    o_data;
    logic [CW-1:0]   o_index;
    logic            o_last;
    logic            sum_valid;
    logic [W-1:0]    sum_xor;
    logic [W+CW-1:0] sum_add;

    nibble_array_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .arr_flat  (arr_flat),
        .busy      (busy),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_index   (o_index),
        .o_last    (o_last),
        .sum_valid (sum_valid),
        .sum_xor   (sum_xor),
        .sum_add   (sum_add)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_mode = 0;
    int hs_count   = 0;
    beat_t exp_q[$];
    sum_t  sum_q[$];
    sum_t  last_sum;
    logic [W-1:0] elem [D0][D1][D2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : ready_driver
        int phase;
        phase = 0;
        o_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: o_ready = 1'b1;
                1: o_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
                default: o_ready = 1'($urandom_range(0, 1));
            endcase
            phase++;
        end
    end

    initial begin : monitor
        logic          stall_q;
        logic [W-1:0]  st_data;
        logic [CW-1:0] st_idx;
        logic          st_last;
        logic          prev_sv;
        int            last_cyc;
        int            prev_hs_cyc;
        beat_t         b;
        sum_t          s;
        stall_q = 1'b0; prev_sv = 1'b0; last_cyc = 0; prev_hs_cyc = 0;
        st_data = '0; st_idx = '0; st_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_q = 1'b0;
                prev_sv = 1'b0;
            end else begin
                if (stall_q && o_valid) begin
                    chk("stall_data_stable", 32'(o_data), 32'(st_data));
                    chk("stall_index_stable", 32'(o_index), 32'(st_idx));
                    chk("stall_last_stable", 32'(o_last), 32'(st_last));
                end
                stall_q = o_valid && !o_ready;
                st_data = o_data; st_idx = o_index; st_last = o_last;
                if (o_valid && o_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        chk("beat_expected", 32'd0, 32'd1);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_data", 32'(o_data), 32'(b.data));
                        chk("beat_index", 32'(o_index), 32'(b.idx));
                        chk("beat_last", 32'(o_last), 32'(b.last));
                        if (ready_mode == 0 && b.idx != 0)
                            chk("back_to_back", 32'(cyc), 32'(prev_hs_cyc + 1));
                    end
                    prev_hs_cyc = cyc;
                    if (o_last) last_cyc = cyc;
                end
                if (sum_valid) begin
                    chk("sum_pulse_single", 32'(prev_sv), 32'd0);
                    chk("sum_after_last", 32'(cyc), 32'(last_cyc + 1));
                    if (sum_q.size() == 0) begin
                        chk("sum_expected", 32'd0, 32'd1);
                    end else begin
                        s = sum_q.pop_front();
                        chk("sum_xor", 32'(sum_xor), 32'(s.x));
                        chk("sum_add", 32'(sum_add), 32'(s.s));
                    end
                end
                prev_sv = sum_valid;
            end
        end
    end

    // Packs elem[][][] into arr_flat, queues the expected stream and sums, then issues start.
    task automatic start_stream();
        logic [N*W-1:0] packed_v;
        int             k;
        sum_t           s;
        beat_t          b;
        packed_v = '0;
        k = 0;
        s.x = '0;
        s.s = '0;
        for (int a = 0; a < D0; a++)
            for (int bb = 0; bb < D1; bb++)
                for (int c = D2 - 1; c >= 0; c--) begin
                    packed_v[flat_index(a, bb, c)*W +: W] = elem[a][bb][c];
                    b.data = elem[a][bb][c];
                    b.idx  = CW'(k);
                    b.last = (k == N - 1);
                    exp_q.push_back(b);
                    s.x = s.x ^ elem[a][bb][c];
                    s.s = s.s + (W+CW)'(elem[a][bb][c]);
                    k++;
                end
        sum_q.push_back(s);
        last_sum = s;
        @(posedge clk); #1;
        arr_flat = packed_v;
        hs_count = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_in_load", 32'(busy), 32'd1);
        chk("no_valid_in_load", 32'(o_valid), 32'd0);
        @(negedge clk);
        chk("first_valid_latency", 32'(o_valid), 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sum_q.size() != 0 || busy) && n < 400) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("stream_completes", 32'(n < 400), 32'd1);
        chk("beats_all_seen", 32'(exp_q.size()), 32'd0);
        chk("idle_after_sum", 32'(busy), 32'd0);
        chk("sum_xor_held", 32'(sum_xor), 32'(last_sum.x));
        chk("sum_add_held", 32'(sum_add), 32'(last_sum.s));
    endtask

    task automatic fill(input int mode);
        for (int a = 0; a < D0; a++)
            for (int b = 0; b < D1; b++)
                for (int c = 0; c < D2; c++)
                    case (mode)
                        0: elem[a][b][c] = 4'hA;
                        1: elem[a][b][c] = W'(flat_index(a, b, c) % 16);
                        2: elem[a][b][c] = (a == 0 && b == 0 && c == 2) ? 4'h1 : 4'h0;
                        default: elem[a][b][c] = W'($urandom_range(0, 15));
                    endcase
    endtask

    initial begin : stimulus
        int n;
        rst = 1'b1;
        start = 1'b0;
        arr_flat = '0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_sum_valid", 32'(sum_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_index", 32'(o_index), 32'd0);
        chk("rst_sum_xor", 32'(sum_xor), 32'd0);
        chk("rst_sum_add", 32'(sum_add), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);

        ready_mode = 0; fill(0); start_stream(); wait_done();
        chk("all_a_xor", 32'(sum_xor), 32'h0);
        chk("all_a_add", 32'(sum_add), 32'd240);

        fill(1); start_stream(); wait_done();
        chk("ramp_add", 32'(sum_add), 32'd148);

        ready_mode = 1; start_stream(); wait_done();
        chk("stall_add_matches", 32'(sum_add), 32'd148);

        fill(3); start_stream();
        @(posedge clk); #1;
        arr_flat = {N{4'hF}};
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("busy_during_stream", 32'(busy), 32'd1);
        end
        wait_done();

        ready_mode = 0; fill(3); start_stream();
        n = 0;
        while (hs_count < 10 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("reached_beat_10", 32'(hs_count >= 10), 32'd1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_sum_valid", 32'(sum_valid), 32'd0);
        chk("midrst_sum_xor", 32'(sum_xor), 32'd0);
        chk("midrst_sum_add", 32'(sum_add), 32'd0);
        exp_q.delete();
        sum_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        start_stream(); wait_done();

        fill(2); start_stream(); wait_done();
        chk("single_xor", 32'(sum_xor), 32'h1);
        chk("single_add", 32'(sum_add), 32'd1);

        ready_mode = 2;
        for (int t = 0; t < 3; t++) begin
            fill(3); start_stream(); wait_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
